// File: rtl/rf_write_arbiter_if.sv
// Bundle of the write-arbiter signals: WB source, long-latency source, ID hazard
// query and the register-file write port.
interface rf_write_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic             a_wb_en;
    logic [3:0]       a_dest;
    logic [WIDTH-1:0] a_value;
    logic             a_stall;

    logic             b_valid;
    logic [3:0]       b_dest;
    logic [WIDTH-1:0] b_value;
    logic             b_ready;

    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_two_src;
    logic             pend_hazard;

    logic             rf_wb_en;
    logic [3:0]       rf_dest;
    logic [WIDTH-1:0] rf_value;
    logic [CntW-1:0]  fifo_count;

    // Arbiter side
    modport slave (
        input  a_wb_en, a_dest, a_value, b_valid, b_dest, b_value,
        input  id_src1, id_src2, id_two_src,
        output a_stall, b_ready, pend_hazard, rf_wb_en, rf_dest, rf_value, fifo_count
    );

    // Pipeline / environment side
    modport master (
        output a_wb_en, a_dest, a_value, b_valid, b_dest, b_value,
        output id_src1, id_src2, id_two_src,
        input  a_stall, b_ready, pend_hazard, rf_wb_en, rf_dest, rf_value, fifo_count
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the in-order WB stage (A)
// and a long-latency result source (B). B results that lose the port are held
// in a small FIFO; a starvation counter periodically freezes WB so they drain.
module rf_write_arbiter #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
    localparam logic [StW-1:0]  LimitC = StW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        GntNone,
        GntForce,
        GntA,
        GntHead,
        GntBypass
    } grant_e;

    logic [3:0]       dest_q [DEPTH];
    logic [WIDTH-1:0] value_q[DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [StW-1:0]   starve_q, starve_d;
    logic             force_q, force_d;

    grant_e grant;
    logic   fifo_empty;
    logic   fifo_full;
    logic   push;
    logic   pop;
    logic   b_live;
    logic   hit1;
    logic   hit2;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DepthC);

    // Port grant in fixed priority; everything is suppressed while reset is held
    always_comb begin
        grant = GntNone;
        if (!rst) begin
            grant = GntNone;
        end else if (force_q && !fifo_empty) begin
            grant = GntForce;
        end else if (bus.a_wb_en) begin
            grant = GntA;
        end else if (!fifo_empty) begin
            grant = GntHead;
        end else if (bus.b_valid) begin
            grant = GntBypass;
        end
    end

    // Drive the register-file port from the granted source
    always_comb begin
        bus.rf_wb_en = 1'b0;
        bus.rf_dest  = '0;
        bus.rf_value = '0;
        bus.a_stall  = 1'b0;
        pop          = 1'b0;
        unique case (grant)
            GntForce: begin
                bus.rf_wb_en = 1'b1;
                bus.rf_dest  = dest_q[rd_ptr_q];
                bus.rf_value = value_q[rd_ptr_q];
                bus.a_stall  = 1'b1;
                pop          = 1'b1;
            end
            GntA: begin
                bus.rf_wb_en = 1'b1;
                bus.rf_dest  = bus.a_dest;
                bus.rf_value = bus.a_value;
            end
            GntHead: begin
                bus.rf_wb_en = 1'b1;
                bus.rf_dest  = dest_q[rd_ptr_q];
                bus.rf_value = value_q[rd_ptr_q];
                pop          = 1'b1;
            end
            GntBypass: begin
                bus.rf_wb_en = 1'b1;
                bus.rf_dest  = bus.b_dest;
                bus.rf_value = bus.b_value;
            end
            default: begin
                bus.rf_wb_en = 1'b0;
            end
        endcase
    end

    // Ready depends only on registered occupancy, never on this cycle's pop
    assign bus.b_ready    = rst && !fifo_full;
    assign push           = bus.b_valid && bus.b_ready && (grant != GntBypass);
    assign bus.fifo_count = count_q;

    // FIFO pointer/occupancy and starvation next-state
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        starve_d = '0;
        force_d  = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Counts only cycles where a buffered entry waited behind A
        if (!fifo_empty && (grant == GntA)) begin
            starve_d = (starve_q == LimitC) ? starve_q : starve_q + 1'b1;
        end
        force_d = (starve_d == LimitC) && (count_d != '0);
    end

    // Destination match against live FIFO entries and a non-bypassed B offer
    always_comb begin
        logic [PtrW-1:0] off;
        hit1   = 1'b0;
        hit2   = 1'b0;
        b_live = bus.b_valid && (grant != GntBypass);
        for (int i = 0; i < int'(DEPTH); i++) begin
            off = PtrW'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) begin
                if (dest_q[i] == bus.id_src1) hit1 = 1'b1;
                if (dest_q[i] == bus.id_src2) hit2 = 1'b1;
            end
        end
        if (b_live && (bus.b_dest == bus.id_src1)) hit1 = 1'b1;
        if (b_live && (bus.b_dest == bus.id_src2)) hit2 = 1'b1;
        bus.pend_hazard = rst && (hit1 || (bus.id_two_src && hit2));
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            force_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            force_q  <= force_d;
        end
    end

    // FIFO storage, written at the tail on accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else if (push) begin
            dest_q[wr_ptr_q]  <= bus.b_dest;
            value_q[wr_ptr_q] <= bus.b_value;
        end
    end
endmodule
